// File: rtl/cgra_cfg_pkg.sv
//------------------------------------------------------------------------------
// Module      : cgra_cfg_pkg
// Description : Shared types and constants for the CGRA configuration loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cgra_cfg_pkg;

    // Width of the saturating stall counter exposed by the loader.
    localparam int STALL_CNT_W = 16;

    // Loader sequencing states; encodings are fixed so they can be mirrored
    // as plain logic constants in legacy code.
    typedef enum logic [2:0] {
        LS_IDLE      = 3'd0,
        LS_WAIT_WORD = 3'd1,
        LS_SHIFT     = 3'd2,
        LS_PULSE_RST = 3'd3,
        LS_RUN       = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/cfg_shift_reg.sv
//------------------------------------------------------------------------------
// Module      : cfg_shift_reg
// Description : Parallel-load, MSB-first left shift register feeding the
//               serial configuration chain.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cfg_shift_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              sync_reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] data,
    output logic              msb
);

    logic [WORD_W-1:0] r_data;

    // Load has priority so a back-to-back word replaces the spent one.
    always_ff @(posedge clock) begin
        if (!sync_reset_n) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= data;
        end else if (shift) begin
            r_data <= {r_data[WORD_W-2:0], 1'b0};
        end
    end

    assign msb = r_data[WORD_W-1];

endmodule

`default_nettype wire

// File: rtl/config_stream_loader.sv
//------------------------------------------------------------------------------
// Module      : config_stream_loader
// Description : Accepts configuration words over valid/ready, serialises them
//               MSB-first onto the CGRA config chain, then pulses the CGRA
//               reset for one cycle and holds the CGRA enabled.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module config_stream_loader
    import cgra_cfg_pkg::*;
#(
    parameter int BITSTREAM_LEN = 1024,
    parameter int WORD_W        = 32,
    parameter int CNT_W         = $clog2(BITSTREAM_LEN + 1)
) (
    input  logic                   clock,
    input  logic                   sync_reset_n,
    input  logic                   start,
    input  logic [WORD_W-1:0]      word_data,
    input  logic                   word_valid,
    output logic                   word_ready,
    output logic                   config_bit,
    output logic                   config_clock_en,
    output logic                   cgra_reset,
    output logic                   cgra_enable,
    output logic                   done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [2:0] c_ST_IDLE  = LS_IDLE;
    localparam logic [2:0] c_ST_WAIT  = LS_WAIT_WORD;
    localparam logic [2:0] c_ST_SHIFT = LS_SHIFT;
    localparam logic [2:0] c_ST_PULSE = LS_PULSE_RST;
    localparam logic [2:0] c_ST_RUN   = LS_RUN;

    localparam int                     c_WB_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]       c_LEN       = CNT_W'(BITSTREAM_LEN);
    localparam logic [c_WB_W-1:0]      c_WORD_BITS = c_WB_W'(WORD_W);
    localparam logic [STALL_CNT_W-1:0] c_STALL_MAX = '1;

    logic [2:0]             r_state;
    logic [CNT_W-1:0]       r_remaining;
    logic [c_WB_W-1:0]      r_word_bits;
    logic [STALL_CNT_W-1:0] r_stall;
    logic                   r_word_ready;
    logic                   r_config_clock_en;
    logic                   r_cgra_reset;
    logic                   r_cgra_enable;
    logic                   r_done;

    logic [2:0]             w_state_nxt;
    logic [CNT_W-1:0]       w_remaining_nxt;
    logic [CNT_W-1:0]       w_remaining_dec;
    logic [c_WB_W-1:0]      w_word_bits_nxt;
    logic [STALL_CNT_W-1:0] w_stall_nxt;
    logic                   w_ready_nxt;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_shift;
    logic                   w_msb;

    // Bits to take from a freshly loaded word: a whole word, or only the top
    // 'rem' bits of the final partial word.
    function automatic logic [c_WB_W-1:0] f_word_bits(input logic [CNT_W-1:0] rem);
        if (int'(rem) >= WORD_W) begin
            return c_WORD_BITS;
        end
        return c_WB_W'(rem);
    endfunction

    assign w_accept        = word_valid & r_word_ready;
    assign w_remaining_dec = r_remaining - CNT_W'(1);

    // Next-state and counter update for the load sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_word_bits_nxt = r_word_bits;
        w_stall_nxt     = r_stall;
        w_load          = 1'b0;
        w_shift         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = c_ST_WAIT;
                    w_remaining_nxt = c_LEN;
                    w_stall_nxt     = '0;
                end
            end
            c_ST_WAIT: begin
                if (w_accept) begin
                    w_load          = 1'b1;
                    w_word_bits_nxt = f_word_bits(r_remaining);
                    w_state_nxt     = c_ST_SHIFT;
                end else if (r_stall != c_STALL_MAX) begin
                    w_stall_nxt = r_stall + STALL_CNT_W'(1);
                end
            end
            c_ST_SHIFT: begin
                w_shift         = 1'b1;
                w_remaining_nxt = w_remaining_dec;
                w_word_bits_nxt = r_word_bits - c_WB_W'(1);
                if (r_word_bits == c_WB_W'(1)) begin
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = c_ST_PULSE;
                    end else if (w_accept) begin
                        // Reload in the same cycle so the stream has no bubble.
                        w_load          = 1'b1;
                        w_word_bits_nxt = f_word_bits(w_remaining_dec);
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_PULSE: begin
                w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (start) begin
                    w_state_nxt     = c_ST_WAIT;
                    w_remaining_nxt = c_LEN;
                    w_stall_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Ready is registered, so it is derived from where the FSM goes next:
    // waiting for data, or about to emit the last bit of a non-final word.
    assign w_ready_nxt = (w_state_nxt == c_ST_WAIT) ||
                         ((w_state_nxt == c_ST_SHIFT) &&
                          (w_word_bits_nxt == c_WB_W'(1)) &&
                          (w_remaining_nxt != CNT_W'(1)));

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!sync_reset_n) begin
            r_state           <= c_ST_IDLE;
            r_remaining       <= '0;
            r_word_bits       <= '0;
            r_stall           <= '0;
            r_word_ready      <= 1'b0;
            r_config_clock_en <= 1'b0;
            r_cgra_reset      <= 1'b0;
            r_cgra_enable     <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_remaining       <= w_remaining_nxt;
            r_word_bits       <= w_word_bits_nxt;
            r_stall           <= w_stall_nxt;
            r_word_ready      <= w_ready_nxt;
            r_config_clock_en <= (w_state_nxt == c_ST_SHIFT);
            r_cgra_reset      <= (w_state_nxt == c_ST_PULSE);
            r_cgra_enable     <= (w_state_nxt == c_ST_RUN);
            r_done            <= (w_state_nxt == c_ST_RUN);
        end
    end

    cfg_shift_reg #(
        .WORD_W (WORD_W)
    ) u_shift_reg (
        .clock        (clock),
        .sync_reset_n (sync_reset_n),
        .load         (w_load),
        .shift        (w_shift),
        .data         (word_data),
        .msb          (w_msb)
    );

    assign word_ready      = r_word_ready;
    assign config_bit      = w_msb;
    assign config_clock_en = r_config_clock_en;
    assign cgra_reset      = r_cgra_reset;
    assign cgra_enable     = r_cgra_enable;
    assign done            = r_done;
    assign stall_cycles    = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_config_stream_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_config_stream_loader
// Description : Directed bench for config_stream_loader: a 64-bit stream
//               instance and a 40-bit (partial final word) instance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_config_stream_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        sync_reset_n;
    logic        start;
    logic        word_valid;
    logic [31:0] word_data;
    int          sel;

    logic start_a, start_b, valid_a, valid_b;
    logic ready_a, bit_a, en_a, rst_a, enable_a, done_a;
    logic ready_b, bit_b, en_b, rst_b, enable_b, done_b;
    logic [15:0] stall_a, stall_b;

    logic s_ready, s_bit, s_en, s_rst, s_enable, s_done;
    logic [15:0] s_stall;

    // Only the selected instance sees start/valid; the other one idles.
    assign start_a = (sel == 0) && start;
    assign start_b = (sel == 1) && start;
    assign valid_a = (sel == 0) && word_valid;
    assign valid_b = (sel == 1) && word_valid;

    assign s_ready  = (sel == 0) ? ready_a  : ready_b;
    assign s_bit    = (sel == 0) ? bit_a    : bit_b;
    assign s_en     = (sel == 0) ? en_a     : en_b;
    assign s_rst    = (sel == 0) ? rst_a    : rst_b;
    assign s_enable = (sel == 0) ? enable_a : enable_b;
    assign s_done   = (sel == 0) ? done_a   : done_b;
    assign s_stall  = (sel == 0) ? stall_a  : stall_b;

    config_stream_loader #(.BITSTREAM_LEN(64), .WORD_W(32)) dut_a (
        .clock           (clock),
        .sync_reset_n    (sync_reset_n),
        .start           (start_a),
        .word_data       (word_data),
        .word_valid      (valid_a),
        .word_ready      (ready_a),
        .config_bit      (bit_a),
        .config_clock_en (en_a),
        .cgra_reset      (rst_a),
        .cgra_enable     (enable_a),
        .done            (done_a),
        .stall_cycles    (stall_a)
    );

    config_stream_loader #(.BITSTREAM_LEN(40), .WORD_W(32)) dut_b (
        .clock           (clock),
        .sync_reset_n    (sync_reset_n),
        .start           (start_b),
        .word_data       (word_data),
        .word_valid      (valid_b),
        .word_ready      (ready_b),
        .config_bit      (bit_b),
        .config_clock_en (en_b),
        .cgra_reset      (rst_b),
        .cgra_enable     (enable_b),
        .done            (done_b),
        .stall_cycles    (stall_b)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic bits[$];
    int   en_cnt, rst_cnt, first_en, last_en, rst_at, done_at;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        bits.delete();
        en_cnt   = 0;
        rst_cnt  = 0;
        first_en = -1;
        last_en  = -1;
        rst_at   = -1;
        done_at  = -1;
    endtask

    // Advance one clock, then sample the selected instance 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (s_en) begin
            bits.push_back(s_bit);
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
        end
        if (s_rst) begin
            rst_cnt++;
            rst_at = cyc;
        end
        if (s_done && done_at < 0) done_at = cyc;
    endtask

    function automatic logic [63:0] packed_bits();
        logic [63:0] v;
        v = '0;
        foreach (bits[i]) v = {v[62:0], bits[i]};
        return v;
    endfunction

    // Start a load, feed two words and check the whole sequence through RUN.
    task automatic load_stream(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input int gap, input bit mid_start, input int nbits,
                               input logic [63:0] exp_bits);
        int nacc;
        int guard;
        bit acc;
        clear_log();
        start = 1'b1;
        step();
        start = 1'b0;
        chk1({tag, "/ready_after_start"}, s_ready, 1'b1);
        chk1({tag, "/enable_after_start"}, s_enable, 1'b0);
        chk1({tag, "/done_after_start"}, s_done, 1'b0);
        chk1({tag, "/en_after_start"}, s_en, 1'b0);
        word_data  = w0;
        word_valid = 1'b1;
        step();
        chk1({tag, "/first_bit_en"}, s_en, 1'b1);
        chk1({tag, "/first_bit_value"}, s_bit, w0[31]);
        word_data = w1;
        if (mid_start) begin
            step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
        if (gap > 0) begin
            word_valid = 1'b0;
            guard = 0;
            while (!(s_ready && s_en) && guard < 64) begin
                step();
                guard++;
            end
            chk1({tag, "/word0_last_bit"}, s_ready & s_en, 1'b1);
            // Withhold data for 'gap' full wait cycles before offering word 1.
            for (int k = 0; k <= gap; k++) begin
                step();
                chk1({tag, "/en_low_in_stall"}, s_en, 1'b0);
            end
            word_valid = 1'b1;
        end
        nacc  = 1;
        guard = 0;
        while (!s_done && guard < 200) begin
            acc = s_ready && word_valid;
            step();
            if (acc) begin
                nacc++;
                word_valid = 1'b0;
            end
            guard++;
        end
        chk1({tag, "/done_reached"}, s_done, 1'b1);
        chk64({tag, "/bit_count"}, 64'(en_cnt), 64'(nbits));
        chk64({tag, "/bit_span"}, 64'(last_en - first_en + 1),
              64'(nbits + ((gap > 0) ? gap + 1 : 0)));
        chk64({tag, "/bitstream"}, packed_bits(), exp_bits);
        chk64({tag, "/words_taken"}, 64'(nacc), 64'(2));
        chk64({tag, "/reset_pulses"}, 64'(rst_cnt), 64'(1));
        chk64({tag, "/reset_cycle"}, 64'(rst_at), 64'(last_en + 1));
        chk64({tag, "/done_cycle"}, 64'(done_at), 64'(last_en + 2));
        chk64({tag, "/stall_cycles"}, 64'(s_stall), 64'(gap));
        chk1({tag, "/enable_in_run"}, s_enable, 1'b1);
        chk1({tag, "/ready_in_run"}, s_ready, 1'b0);
        step();
        step();
        chk1({tag, "/done_held"}, s_done, 1'b1);
    endtask

    initial begin
        int guard;
        sel          = 0;
        sync_reset_n = 1'b0;
        start        = 1'b0;
        word_valid   = 1'b0;
        word_data    = '0;
        clear_log();
        step();
        step();
        chk1("reset/ready", s_ready, 1'b0);
        chk1("reset/bit", s_bit, 1'b0);
        chk1("reset/en", s_en, 1'b0);
        chk1("reset/cgra_reset", s_rst, 1'b0);
        chk1("reset/enable", s_enable, 1'b0);
        chk1("reset/done", s_done, 1'b0);
        chk64("reset/stall", 64'(s_stall), 64'(0));
        sync_reset_n = 1'b1;
        step();

        // Back-to-back words with valid held.
        load_stream("base", 32'hA5A5_A5A5, 32'h0000_FFFF, 0, 1'b0, 64, 64'hA5A5_A5A5_0000_FFFF);

        // Re-arm from RUN, with a stray start pulse in the middle of shifting.
        load_stream("rearm", 32'h0F0F_1234, 32'hDEAD_BEEF, 0, 1'b1, 64, 64'h0F0F_1234_DEAD_BEEF);

        // Five-cycle data stall between the two words.
        load_stream("gap", 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0, 64, 64'h1234_5678_9ABC_DEF0);

        // Reset after 10 bits of a load.
        clear_log();
        start = 1'b1;
        step();
        start      = 1'b0;
        word_data  = 32'hC3C3_0F0F;
        word_valid = 1'b1;
        guard = 0;
        while (en_cnt < 10 && guard < 50) begin
            step();
            guard++;
        end
        chk64("midrst/bits_before", 64'(en_cnt), 64'(10));
        sync_reset_n = 1'b0;
        step();
        sync_reset_n = 1'b1;
        chk1("midrst/ready", s_ready, 1'b0);
        chk1("midrst/bit", s_bit, 1'b0);
        chk1("midrst/en", s_en, 1'b0);
        chk1("midrst/cgra_reset", s_rst, 1'b0);
        chk1("midrst/enable", s_enable, 1'b0);
        chk1("midrst/done", s_done, 1'b0);
        chk64("midrst/stall", 64'(s_stall), 64'(0));

        // Valid with no start while idle: nothing accepted, nothing shifted.
        for (int k = 0; k < 5; k++) begin
            step();
            chk1("idle_valid/ready", s_ready, 1'b0);
            chk1("idle_valid/en", s_en, 1'b0);
        end
        word_valid = 1'b0;
        load_stream("after_rst", 32'h3C5A_96E1, 32'h0123_4567, 0, 1'b0, 64, 64'h3C5A_96E1_0123_4567);

        // 40-bit stream: only the top 8 bits of the second word are used.
        sel = 1;
        step();
        load_stream("short", 32'hFFFF_FFFF, 32'hF000_0000, 0, 1'b0, 40, 64'h0000_00FF_FFFF_FFF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule

`default_nettype wire
